// File: rtl/uart_packet_arbiter_if.sv
// Byte-stream bundle between packet sources, the arbiter/framer and the TX FIFO write side.
// master = sources + TX FIFO side, slave = uart_packet_arbiter.
interface uart_packet_arbiter_if #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [NUM_SRC-1:0]            src_req;
  logic [NUM_SRC*8-1:0]          src_len;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_rd;
  logic [NUM_SRC-1:0]            src_grant;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          busy;
  logic [15:0]                   pkt_count;

  modport master (
    output src_req, src_len, src_data, tx_ready,
    input  src_rd, src_grant, tx_data, tx_valid, busy, pkt_count
  );

  modport slave (
    input  src_req, src_len, src_data, tx_ready,
    output src_rd, src_grant, tx_data, tx_valid, busy, pkt_count
  );
endinterface

// File: rtl/uart_packet_arbiter.sv
// Round-robin packet arbiter/framer: SOF, id, length, payload[, XOR checksum] per frame.
// Define PKT_CHECKSUM_EN to append the checksum trailer byte (CHK state).
module uart_packet_arbiter #(
  parameter int unsigned           NUM_SRC    = 4,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = DATA_WIDTH'(8'hA5)
) (
  input logic                  clk_i,
  input logic                  rst_i,
  uart_packet_arbiter_if.slave bus_io
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  typedef logic [IdxW-1:0] idx_t;

`ifdef PKT_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StSof, StId, StLen, StPayload, StChk, StDone} state_e;
  localparam state_e StTail = StChk;
`else
  typedef enum logic [2:0] {StIdle, StSof, StId, StLen, StPayload, StDone} state_e;
  localparam state_e StTail = StDone;
`endif

  state_e                state_q, state_d;
  idx_t                  rr_ptr_q, rr_ptr_d;
  idx_t                  gnt_q, gnt_d;
  logic [7:0]            len_cnt_q, len_cnt_d;
  logic [15:0]           pkt_count_q, pkt_count_d;

  logic                  req_found;
  idx_t                  req_idx;
  idx_t                  cand;
  logic [7:0]            req_len;
  logic [DATA_WIDTH-1:0] payload;
  logic                  xfer;

  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [NUM_SRC-1:0]    src_rd;
  logic [NUM_SRC-1:0]    src_grant;

  // First requester at or above rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = idx_t'((32'(rr_ptr_q) + k) % NUM_SRC);
      if (!req_found && bus_io.src_req[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  always_comb begin
    req_len = '0;
    payload = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (idx_t'(k) == req_idx) req_len = bus_io.src_len[k*8 +: 8];
      if (idx_t'(k) == gnt_q)   payload = bus_io.src_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign xfer = tx_valid & bus_io.tx_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      len_cnt_q   <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      len_cnt_q   <= len_cnt_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_found) state_d = StSof;
      StSof:     if (xfer) state_d = StId;
      StId:      if (xfer) state_d = StLen;
      StLen:     if (xfer) state_d = (len_cnt_q != 8'd0) ? StPayload : StTail;
      StPayload: if (xfer && len_cnt_q == 8'd1) state_d = StTail;
`ifdef PKT_CHECKSUM_EN
      StChk:     if (xfer) state_d = StDone;
`endif
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    len_cnt_d   = len_cnt_q;
    pkt_count_d = pkt_count_q;
    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          gnt_d     = req_idx;
          len_cnt_d = req_len;
        end
      end
      StPayload: if (xfer) len_cnt_d = len_cnt_q - 8'd1;
      StDone: begin
        pkt_count_d = pkt_count_q + 16'd1;
        rr_ptr_d    = (gnt_q == idx_t'(NUM_SRC - 1)) ? '0 : gnt_q + idx_t'(1);
      end
      default: ;
    endcase
  end

`ifdef PKT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;

  // ID, LEN and payload states each fold the byte currently on tx_data.
  always_comb begin
    chk_d = chk_q;
    unique case (state_q)
      StIdle:                 if (req_found) chk_d = '0;
      StId, StLen, StPayload: if (xfer) chk_d = chk_q ^ tx_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) chk_q <= '0;
    else       chk_q <= chk_d;
  end
`endif

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    src_rd    = '0;
    src_grant = '0;
    unique case (state_q)
      StSof: begin
        tx_valid = 1'b1;
        tx_data  = SOF_BYTE;
      end
      StId: begin
        tx_valid = 1'b1;
        tx_data  = DATA_WIDTH'(gnt_q);
      end
      StLen: begin
        tx_valid = 1'b1;
        tx_data  = DATA_WIDTH'(len_cnt_q);
      end
      StPayload: begin
        tx_valid       = 1'b1;
        tx_data        = payload;
        src_rd[gnt_q]  = bus_io.tx_ready;
      end
`ifdef PKT_CHECKSUM_EN
      StChk: begin
        tx_valid = 1'b1;
        tx_data  = chk_q;
      end
`endif
      default: ;
    endcase
    if (state_q != StIdle && state_q != StDone) src_grant[gnt_q] = 1'b1;
  end

  assign bus_io.tx_valid  = tx_valid;
  assign bus_io.tx_data   = tx_data;
  assign bus_io.src_rd    = src_rd;
  assign bus_io.src_grant = src_grant;
  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_uart_packet_arbiter.sv
// Bench for uart_packet_arbiter: queue-backed sources, byte/grant scoreboard against a frame model.
module tb_uart_packet_arbiter;
  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DW      = 8;
  localparam logic [7:0]  SOF     = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_packet_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW)) bus ();

  uart_packet_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .DATA_WIDTH (DW),
    .SOF_BYTE   (SOF)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;

  // Source-side state: pending packet lengths and concatenated payload bytes per source.
  int         plen  [NUM_SRC][$];
  logic [7:0] pay   [NUM_SRC][$];
  // Model-side copies consumed by model_run().
  int         m_len [NUM_SRC][$];
  logic [7:0] m_dat [NUM_SRC][$];

  logic [7:0] got[$];
  logic [7:0] exp_b[$];
  int         got_g[$];
  int         exp_g[$];
  int         m_ptr = 0;
  int         exp_pkts = 0;
  int         ready_mode = 0;
  int         cyc = 0;
  int         pops_total [NUM_SRC];

  logic [NUM_SRC-1:0] pop_pend = '0;
  logic [NUM_SRC-1:0] rise_pend = '0;
  logic [NUM_SRC-1:0] prev_grant = '0;
  logic               prev_stall = 1'b0;
  logic [7:0]         prev_data = '0;

  typedef struct {
    int              src;
    int              len;
    logic [2:0][7:0] d;
    int              rmode;
    logic [7:0]      chk;
    int              nbytes;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_pkt(input int s, input int len);
    plen[s].push_back(len);
    m_len[s].push_back(len);
  endtask

  task automatic add_byte(input int s, input logic [7:0] b);
    pay[s].push_back(b);
    m_dat[s].push_back(b);
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NUM_SRC; i++) begin
      plen[i].delete();
      pay[i].delete();
      m_len[i].delete();
      m_dat[i].delete();
    end
  endtask

  // Frame model: every pending packet is requesting; round-robin from m_ptr.
  task automatic model_run();
    bit         done;
    int         g;
    int         len;
    logic [7:0] x;
    logic [7:0] b;
    done = 1'b0;
    while (!done) begin
      g = -1;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (g < 0 && m_len[(m_ptr + k) % NUM_SRC].size() != 0) g = (m_ptr + k) % NUM_SRC;
      end
      if (g < 0) begin
        done = 1'b1;
      end else begin
        len = m_len[g].pop_front();
        x   = 8'(g) ^ 8'(len);
        exp_b.push_back(SOF);
        exp_b.push_back(8'(g));
        exp_b.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
          b = m_dat[g].pop_front();
          x = x ^ b;
          exp_b.push_back(b);
        end
`ifdef PKT_CHECKSUM_EN
        exp_b.push_back(x);
`endif
        exp_g.push_back(g);
        m_ptr = (g + 1) % NUM_SRC;
        exp_pkts++;
      end
    end
  endtask

  task automatic wait_pkts(input string name);
    int n;
    n = 0;
    while (bus.pkt_count != 16'(exp_pkts) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.pkt_count), 32'(exp_pkts));
    @(negedge clk);
  endtask

  task automatic compare(input string name);
    int n;
    check($sformatf("%s_nbytes", name), 32'(got.size()), 32'(exp_b.size()));
    n = (got.size() < exp_b.size()) ? got.size() : exp_b.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp_b[i]));
    check($sformatf("%s_nframes", name), 32'(got_g.size()), 32'(exp_g.size()));
    n = (got_g.size() < exp_g.size()) ? got_g.size() : exp_g.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_grant%0d", name, i), 32'(got_g[i]), 32'(exp_g[i]));
    got.delete();
    exp_b.delete();
    got_g.delete();
    exp_g.delete();
  endtask

  // Source/sink driver: applies pops and grant acceptance one cycle after they are seen.
  initial begin
    bus.src_req  = '0;
    bus.src_len  = '0;
    bus.src_data = '0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) pops_total[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pop_pend[i] && pay[i].size() != 0) begin
          pay[i].delete(0);
          pops_total[i]++;
        end
        if (rise_pend[i] && plen[i].size() != 0) plen[i].delete(0);
        bus.src_req[i]          = (plen[i].size() != 0);
        bus.src_len[i*8 +: 8]   = (plen[i].size() != 0) ? 8'(plen[i][0]) : 8'h00;
        bus.src_data[i*8 +: 8]  = (pay[i].size() != 0) ? pay[i][0] : 8'h00;
      end
      case (ready_mode)
        1:       bus.tx_ready = (cyc % 3 == 0);
        2:       bus.tx_ready = 1'($urandom_range(0, 1));
        default: bus.tx_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.tx_valid), 32'd1);
        check("stall_data", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.tx_valid && !bus.tx_ready) check("rd_while_stalled", 32'(bus.src_rd), 32'd0);
      if (bus.src_rd != '0) check("rd_vs_grant", 32'(bus.src_rd), 32'(bus.src_grant));
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.src_grant[i] && !prev_grant[i]) got_g.push_back(i);
      end
    end
    pop_pend   = bus.src_rd;
    rise_pend  = bus.src_grant & ~prev_grant;
    prev_grant = bus.src_grant;
    prev_stall = bus.tx_valid & ~bus.tx_ready & ~rst;
    prev_data  = bus.tx_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   vtrace[$];
    int   n;
    int   run;
    int   ngap;
    bit   seen1;
    int   p0;
    int   total;
    int   s;
    int   len;

    tbl[0] = '{src: 0, len: 3, d: {8'h33, 8'h22, 8'h11}, rmode: 0, chk: 8'h03, nbytes: 7};
    tbl[1] = '{src: 0, len: 3, d: {8'h33, 8'h22, 8'h11}, rmode: 1, chk: 8'h03, nbytes: 7};
    tbl[2] = '{src: 2, len: 0, d: {8'h00, 8'h00, 8'h00}, rmode: 0, chk: 8'h02, nbytes: 4};
    tbl[3] = '{src: 1, len: 2, d: {8'h00, 8'h0F, 8'hF0}, rmode: 1, chk: 8'hFC, nbytes: 6};
    tbl[4] = '{src: 3, len: 1, d: {8'h00, 8'h00, 8'h80}, rmode: 2, chk: 8'h82, nbytes: 5};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_grant", 32'(bus.src_grant), 32'd0);
    check("rst_rd", 32'(bus.src_rd), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All four requesting, src0 with a second packet: order 0,1,2,3,0 and 2 dead cycles.
    ready_mode = 0;
    add_pkt(0, 1); add_byte(0, 8'h10);
    add_pkt(0, 1); add_byte(0, 8'h14);
    for (int i = 1; i < NUM_SRC; i++) begin
      add_pkt(i, 1);
      add_byte(i, 8'(8'h10 + i));
    end
    model_run();
    n = 0;
    while (bus.pkt_count != 16'(exp_pkts) && n < 500) begin
      @(negedge clk);
      vtrace.push_back(bus.tx_valid);
      n++;
    end
    check("rr_done", 32'(bus.pkt_count), 32'(exp_pkts));
    @(negedge clk);
    run = 0; ngap = 0; seen1 = 1'b0;
    foreach (vtrace[i]) begin
      if (vtrace[i]) begin
        if (seen1 && run > 0) begin
          check($sformatf("rr_gap%0d", ngap), 32'(run), 32'd2);
          ngap++;
        end
        seen1 = 1'b1;
        run   = 0;
      end else begin
        run++;
      end
    end
    check("rr_gap_count", 32'(ngap), 32'd4);
    for (int k = 0; k < 5; k++) begin
      if (k < got_g.size()) check($sformatf("rr_order%0d", k), 32'(got_g[k]), 32'(k % 4));
    end
    compare("rr");

    // Directed single-frame vectors.
    for (int t = 0; t < 5; t++) begin
      p0 = pops_total[tbl[t].src];
      ready_mode = tbl[t].rmode;
      add_pkt(tbl[t].src, tbl[t].len);
      for (int k = 0; k < tbl[t].len; k++) add_byte(tbl[t].src, tbl[t].d[k]);
      model_run();
      wait_pkts($sformatf("vec%0d_done", t));
`ifdef PKT_CHECKSUM_EN
      check($sformatf("vec%0d_len", t), 32'(got.size()), 32'(tbl[t].nbytes));
      if (got.size() != 0) check($sformatf("vec%0d_chk", t), 32'(got[got.size()-1]), 32'(tbl[t].chk));
`else
      check($sformatf("vec%0d_len", t), 32'(got.size()), 32'(tbl[t].nbytes - 1));
`endif
      check($sformatf("vec%0d_pops", t), 32'(pops_total[tbl[t].src] - p0), 32'(tbl[t].len));
      compare($sformatf("vec%0d", t));
    end

    // Randomised bursts with random back-pressure.
    for (int r = 0; r < 6; r++) begin
      ready_mode = 2;
      total = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++) begin
          len = $urandom_range(0, 6);
          add_pkt(i, len);
          for (int k = 0; k < len; k++) add_byte(i, 8'($urandom));
          total++;
        end
      end
      if (total == 0) begin
        s = $urandom_range(0, NUM_SRC - 1);
        add_pkt(s, 2);
        add_byte(s, 8'($urandom));
        add_byte(s, 8'($urandom));
      end
      model_run();
      wait_pkts($sformatf("rnd%0d_done", r));
      compare($sformatf("rnd%0d", r));
    end

    // Leave rr_ptr at 2, then abandon a len=5 frame from src2 with a reset.
    ready_mode = 0;
    add_pkt(1, 1); add_byte(1, 8'h5A);
    model_run();
    wait_pkts("pre_rst_done");
    compare("pre_rst");
    p0 = pops_total[2];
    add_pkt(2, 5);
    for (int k = 0; k < 5; k++) add_byte(2, 8'(8'hC0 + k));
    n = 0;
    while (pops_total[2] < p0 + 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached", 32'(pops_total[2] - p0), 32'd1);
    rst = 1'b1;
    flush_sources();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("midrst_grant", 32'(bus.src_grant), 32'd0);
    check("midrst_pkt_count", 32'(bus.pkt_count), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    got.delete(); got_g.delete(); exp_b.delete(); exp_g.delete();
    exp_pkts = 0;
    m_ptr    = 0;
    add_pkt(2, 1); add_byte(2, 8'h77);
    add_pkt(0, 1); add_byte(0, 8'h66);
    model_run();
    wait_pkts("post_rst_done");
    if (got_g.size() != 0) check("post_rst_first_grant", 32'(got_g[0]), 32'd0);
    compare("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
